// File: rtl/fetch_unit.sv
// fetch_unit: PC, request/grant/response fetch port and an in-order instruction FIFO feeding decode.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] NOP_INST   = 32'h0000_0001
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   input  logic        stall_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        inst_valid_o
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW+1:0] DEPTH_L = (CW+2)'(FIFO_DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] count_q, count_d, outst_q, outst_d, drop_q, drop_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] sh_rd_q, sh_rd_d, sh_wr_q, sh_wr_d;
   logic [31:0]   last_addr_q, last_addr_d;

   logic [31:0]   fifo_inst_q [FIFO_DEPTH];
   logic [31:0]   fifo_addr_q [FIFO_DEPTH];
   logic [31:0]   sh_addr_q   [FIFO_DEPTH];

   logic [CW+1:0] level;
   logic          grant, rsp_keep, rsp_drop, fifo_empty, head_valid, fifo_pop, push, byp_take;
   logic [31:0]   rsp_addr;

   // Capacity counts buffered, in-flight and to-be-discarded words alike.
   assign level      = {2'b00, count_q} + {2'b00, outst_q} + {2'b00, drop_q};
   assign mem_req_o  = rst_n && !jump_en_i && (level < DEPTH_L);
   assign mem_addr_o = pc_q;
   assign grant      = mem_req_o && mem_gnt_i;
   assign rsp_keep   = mem_rvalid_i && (drop_q == '0);
   assign rsp_drop   = mem_rvalid_i && (drop_q != '0);
   assign rsp_addr   = sh_addr_q[sh_rd_q];
   assign fifo_empty = (count_q == '0);
   assign head_valid = !fifo_empty && !jump_en_i;
   assign fifo_pop   = head_valid && !stall_i;

`ifdef FETCH_BYPASS_EN
   logic byp_hit;
   assign byp_hit  = fifo_empty && rsp_keep && !jump_en_i;
   assign byp_take = byp_hit && !stall_i;
`else
   assign byp_take = 1'b0;
`endif

   assign push = rsp_keep && !jump_en_i && !byp_take;

   always_comb begin
      inst_valid_o = head_valid;
      inst_o       = head_valid ? fifo_inst_q[rd_ptr_q] : NOP_INST;
      inst_addr_o  = head_valid ? fifo_addr_q[rd_ptr_q] : last_addr_q;
`ifdef FETCH_BYPASS_EN
      if (byp_hit) begin
         inst_valid_o = 1'b1;
         inst_o       = mem_rdata_i;
         inst_addr_o  = rsp_addr;
      end
`endif
   end

   always_comb begin
      pc_d        = pc_q;
      count_d     = count_q;
      outst_d     = outst_q;
      drop_d      = drop_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      sh_rd_d     = sh_rd_q;
      sh_wr_d     = sh_wr_q;
      last_addr_d = last_addr_q;
      if (jump_en_i) begin
         // Everything in flight becomes stale; a response landing now is already one of them.
         pc_d     = {jump_addr_i[31:2], 2'b00};
         count_d  = '0;
         rd_ptr_d = wr_ptr_q;
         sh_rd_d  = sh_wr_q;
         outst_d  = '0;
         drop_d   = drop_q + outst_q - (mem_rvalid_i ? CW'(1) : CW'(0));
      end else begin
         if (grant) begin
            pc_d    = pc_q + 32'd4;
            sh_wr_d = sh_wr_q + PW'(1);
         end
         if (rsp_keep) sh_rd_d = sh_rd_q + PW'(1);
         if (rsp_drop) drop_d = drop_q - CW'(1);
         case ({grant, rsp_keep})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
         endcase
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (fifo_pop) begin
            rd_ptr_d    = rd_ptr_q + PW'(1);
            last_addr_d = fifo_addr_q[rd_ptr_q];
         end
         if (byp_take) last_addr_d = rsp_addr;
         case ({push, fifo_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= RESET_PC;
         count_q     <= '0;
         outst_q     <= '0;
         drop_q      <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         sh_rd_q     <= '0;
         sh_wr_q     <= '0;
         last_addr_q <= '0;
      end else begin
         pc_q        <= pc_d;
         count_q     <= count_d;
         outst_q     <= outst_d;
         drop_q      <= drop_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         sh_rd_q     <= sh_rd_d;
         sh_wr_q     <= sh_wr_d;
         last_addr_q <= last_addr_d;
      end
   end

   // Storage arrays carry no reset; validity is tracked by the pointers and counts.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_inst_q[wr_ptr_q] <= mem_rdata_i;
         fifo_addr_q[wr_ptr_q] <= rsp_addr;
      end
      if (grant) sh_addr_q[sh_wr_q] <= pc_q;
   end
endmodule
